// File: rtl/cam_seq_ctrl.sv
// rtl/cam_seq_ctrl.sv - two-requester round-robin sequencer driving an 8x4 CAM lookup/update cycle
module cam_seq_ctrl (
    input  logic       clk,
    input  logic       init_n,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [1:0] req_op,
    input  logic [7:0] req_key,
    input  logic [7:0] req_new,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic       rsp_op,
    output logic       rsp_hit,
    output logic [2:0] rsp_min,
    output logic [2:0] rsp_max,
    output logic [7:0] repl_count,
    output logic [3:0] cam_lookup,
    output logic       cam_setD,
    output logic [3:0] cam_newD,
    output logic       cam_init,
    input  logic       cam_valid,
    input  logic [2:0] cam_min,
    input  logic [2:0] cam_max
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOOK = 2'd1,
        UPD  = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       rr_last;
    logic       cmd_id;
    logic       cmd_op;
    logic [3:0] cmd_key;
    logic [3:0] cmd_new;
    logic [1:0] grant;
    logic       acc_id;
    logic       accept;

    // rr_last names the most recently served requester; the other one wins a tie
    always_comb begin
        grant = 2'b00;
        unique case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr_last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign acc_id = grant[1];

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 2'b00;
        accept    = 1'b0;
        rsp_valid = 1'b0;
        cam_setD  = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = grant & {2{init_n}};
                if (grant != 2'b00) begin
                    accept    = 1'b1;
                    state_nxt = LOOK;
                end
            end
            LOOK: begin
                state_nxt = (cmd_op && cam_valid) ? UPD : RESP;
            end
            UPD: begin
                cam_setD  = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            rr_last    <= 1'b1;
            cmd_id     <= 1'b0;
            cmd_op     <= 1'b0;
            cmd_key    <= 4'd0;
            cmd_new    <= 4'd0;
            rsp_id     <= 1'b0;
            rsp_op     <= 1'b0;
            rsp_hit    <= 1'b0;
            rsp_min    <= 3'd0;
            rsp_max    <= 3'd0;
            repl_count <= 8'd0;
        end else begin
            if (accept) begin
                cmd_id  <= acc_id;
                cmd_op  <= req_op[acc_id];
                cmd_key <= req_key[{acc_id, 2'b00} +: 4];
                cmd_new <= req_new[{acc_id, 2'b00} +: 4];
                rr_last <= acc_id;
            end
            // min/max are captured before any update so they reflect the pre-write match
            if (state == LOOK) begin
                rsp_id  <= cmd_id;
                rsp_op  <= cmd_op;
                rsp_hit <= cam_valid;
                rsp_min <= cam_min;
                rsp_max <= cam_max;
                if (cmd_op && cam_valid && (repl_count != 8'hFF)) begin
                    repl_count <= repl_count + 8'd1;
                end
            end
        end
    end

    assign cam_lookup = cmd_key;
    assign cam_newD   = cmd_new;
    assign cam_init   = ~init_n;

endmodule
